// File: rtl/tempsens_spi_reader.sv
// SPI reader for a serial temperature sensor, paced by a synchronized slow-clock tick.
// Optional macro TEMPSENS_AVG_EN: output the 4-sample moving average instead of the raw field.
module tempsens_spi_reader #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_slow,
    input  logic                 start,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 busy,
    output logic [DATA_BITS-1:0] temp_data,
    output logic                 valid
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t                state, state_nx;
    logic                  sync1, sync2, sync_dly, tick;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [FRAME_BITS-1:0] frame, frame_nx;
    logic                  sclk_nx, cs_n_nx, load;
    logic [DATA_BITS-1:0]  raw, data_nx;

    // tick is high in the cycle after sync2 rises, so the FSM acts on the 3rd clk edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_dly <= 1'b0;
        end else begin
            sync1    <= clk_slow;
            sync2    <= sync1;
            sync_dly <= sync2;
        end
    end
    assign tick = sync2 & ~sync_dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            frame <= '0;
            sclk  <= 1'b0;
            cs_n  <= 1'b1;
            valid <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            frame <= frame_nx;
            sclk  <= sclk_nx;
            cs_n  <= cs_n_nx;
            valid <= load;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        frame_nx = frame;
        sclk_nx  = sclk;
        cs_n_nx  = cs_n;
        load     = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nx = SETUP;
                cs_n_nx  = 1'b0;
            end
            SETUP: if (tick) begin
                state_nx = SHIFT;
                cnt_nx   = '0;
            end
            SHIFT: if (tick) begin
                if (!sclk) begin
                    sclk_nx  = 1'b1;
                    frame_nx = {frame[FRAME_BITS-2:0], miso};
                end else begin
                    sclk_nx = 1'b0;
                    cnt_nx  = cnt + 1'b1;
                    if (cnt == CNT_W'(FRAME_BITS - 1))
                        state_nx = HOLD;
                end
            end
            HOLD: if (tick) begin
                cs_n_nx  = 1'b1;
                state_nx = DONE;
                load     = 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign raw  = frame[FRAME_BITS-1 -: DATA_BITS];

`ifdef TEMPSENS_AVG_EN
    // three older samples plus the incoming one form the 4-sample window
    logic signed [DATA_BITS-1:0] hist [3];
    logic                        primed;
    logic signed [DATA_BITS+1:0] sum, sum_sh;

    always_comb begin
        sum     = $signed(raw) + hist[0] + hist[1] + hist[2];
        sum_sh  = sum >>> 2;
        data_nx = primed ? sum_sh[DATA_BITS-1:0] : raw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed <= 1'b0;
            for (int i = 0; i < 3; i++) hist[i] <= '0;
        end else if (load) begin
            primed <= 1'b1;
            if (!primed) begin
                for (int i = 0; i < 3; i++) hist[i] <= $signed(raw);
            end else begin
                hist[0] <= $signed(raw);
                hist[1] <= hist[0];
                hist[2] <= hist[1];
            end
        end
    end
`else
    always_comb data_nx = raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            temp_data <= '0;
        else if (load)
            temp_data <= data_nx;
    end
endmodule

// File: doc/tempsens_spi_reader.md
TEMPSENS_SPI_READER -- requirements
Module: tempsens_spi_reader

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 16: SPI frame length in bits, captured MSB first.
REQ-002 SHALL have parameter DATA_BITS, default 13: width of the two's-complement temperature field, taken from frame bits [FRAME_BITS-1 : FRAME_BITS-DATA_BITS].
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port clk_slow, input, 1: divided clock from the slow-clock generator, asynchronous to clk, used only as a timing reference.
REQ-006 SHALL have port start, input, 1: single-cycle conversion request.
REQ-007 SHALL have port miso, input, 1: sensor serial data.
REQ-008 SHALL have port sclk, output, 1: SPI clock to the sensor, idle low.
REQ-009 SHALL have port cs_n, output, 1: sensor chip select, active low.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port temp_data, output, DATA_BITS: signed temperature, 0.0625 degC/LSB, held between updates.
REQ-012 SHALL have port valid, output, 1: one-clk pulse when temp_data updates.

Function
REQ-013 SHALL pass clk_slow through a 2-FF synchronizer plus a delay FF; tick SHALL be high for exactly one clk cycle, on the 3rd clk rising edge after clk_slow rises.
REQ-014 SHALL implement states IDLE, SETUP, SHIFT, HOLD, DONE; all transitions except IDLE->SETUP and DONE->IDLE SHALL occur only on tick.
REQ-015 IDLE: cs_n=1, sclk=0; start=1 -> SETUP on the next clk edge, without waiting for tick.
REQ-016 SETUP: cs_n=0 on entry; on the first tick -> SHIFT with bit counter = 0.
REQ-017 SHIFT, tick with sclk=0: sclk->1 and miso shifts into the frame register LSB (left shift).
REQ-018 SHIFT, tick with sclk=1: sclk->0 and counter increments; when the counter reaches FRAME_BITS -> HOLD.
REQ-019 HOLD: sclk=0, cs_n=0; on tick, cs_n->1 and state -> DONE.
REQ-020 DONE: temp_data loads the selected frame field, valid=1 for that single cycle, then -> IDLE; DONE lasts exactly one clk cycle.
REQ-021 start while busy=1 SHALL be ignored and not queued.
REQ-022 start in the same cycle as DONE SHALL be ignored; start in the following cycle (IDLE) SHALL be accepted.
REQ-023 A frame SHALL take exactly 2*FRAME_BITS+2 ticks from SETUP entry to DONE.
REQ-024 If clk_slow stops, the FSM SHALL hold its state with no timeout.

Reset
REQ-025 On reset assertion, immediately and independently of clk: state=IDLE, cs_n=1, sclk=0, busy=0, valid=0, temp_data=0, counter, frame register and synchronizer all 0.
REQ-026 Reset mid-frame SHALL abort the frame with no valid pulse; the first start after reset release SHALL begin a complete new frame.

Configuration
REQ-027 Macro TEMPSENS_AVG_EN: when defined, temp_data SHALL be the arithmetic-shift-right-by-2 of the sum of the last 4 raw samples, held in a 4-entry history with a DATA_BITS+2-bit sum.
REQ-028 With TEMPSENS_AVG_EN, the first sample after reset SHALL preload all 4 history entries; valid timing SHALL be unchanged (same DONE cycle).
REQ-029 Without TEMPSENS_AVG_EN, temp_data SHALL be the raw field and no history registers SHALL exist.

Verification
REQ-030 Sensor model returns 0x0C80, start pulsed -> after 34 ticks: valid pulse, temp_data=0x190 (+25.0 degC), cs_n=1, busy=0.
REQ-031 Sensor returns 0xE700 -> temp_data=0x1CE0 (-50.0 degC, signed -800).
REQ-032 start pulsed at SHIFT bit 5 -> ignored; exactly 16 sclk rising edges and one valid in the frame.
REQ-033 reset asserted at SHIFT bit 8 -> cs_n=1 and sclk=0 in the same cycle, no valid pulse; next start gives a correct full frame.
REQ-034 TEMPSENS_AVG_EN defined, frames with raw values 0x190 then 0x1A0 -> temp_data=0x190, then 0x194.
REQ-035 clk_slow held low mid-SHIFT for 1000 clk cycles -> sclk, cs_n and counter are frozen; the frame completes correctly once clk_slow resumes.
